sample_sched: RTL and testbench

SAMPLE_SCHED -- requirements
Module: sample_sched

---
 rtl/sample_sched.sv | 166 ++++++++++++++++
 tb/tb_sample_sched.sv | 329 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sample_sched.sv
// sample_sched: a free-running timer starts an X then Y read from the accelerometer reader.
// Each completed pair is held as pending and copied to data_x/data_y on a v_sync rising edge.
// Build option: define SAMPLE_SCHED_TIMEOUT_EN to abandon reads that get no rd_ack in time.
module sample_sched #(
    parameter int unsigned SAMPLE_DIV = 50000,
    parameter int unsigned TIMEOUT    = 1023,
    parameter int unsigned W          = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [9:0]   SW,
    input  logic         v_sync,
    output logic         rd_req,
    output logic         rd_axis,
    input  logic         rd_ack,
    input  logic [W-1:0] rd_data,
    output logic [W-1:0] data_x,
    output logic [W-1:0] data_y,
    output logic         data_update,
    output logic [7:0]   err_cnt,
    output logic [7:0]   ovr_cnt
);

    localparam int unsigned TimerW = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;

    typedef enum logic [1:0] {StIdle, StReqX, StReqY} state_e;

    state_e            state_q, state_d;
    logic [TimerW-1:0] timer_q;
    logic              tick;
    logic              vs_prev_q;
    logic              vs_edge;
    logic              pair_done;
    logic              publish;
    logic              abandon;
    logic              pending_q;
    logic [W-1:0]      shadow_x_q;
    logic [W-1:0]      pend_x_q, pend_y_q;
    logic [W-1:0]      data_x_q, data_y_q;
    logic              data_update_q;
    logic [7:0]        ovr_cnt_q;
    logic              unused_sw;

    assign unused_sw = ^SW[9:2];

    assign tick      = (timer_q == TimerW'(SAMPLE_DIV - 1));
    assign vs_edge   = v_sync && !vs_prev_q;
    assign pair_done = (state_q == StReqY) && rd_ack;
    // A frozen edge publishes nothing and leaves the pending pair in place.
    assign publish   = vs_edge && pending_q && !SW[1];

    // Free-running sample timer, wraps at SAMPLE_DIV-1.
    always_ff @(posedge clk) begin
        if (rst || tick) begin
            timer_q <= '0;
        end else begin
            timer_q <= timer_q + 1'b1;
        end
    end

`ifdef SAMPLE_SCHED_TIMEOUT_EN
    localparam int unsigned ToW = $clog2(TIMEOUT + 1);

    logic [ToW-1:0] to_cnt_q;
    logic [7:0]     err_cnt_q;

    assign abandon = (state_q != StIdle) && !rd_ack && (to_cnt_q == ToW'(TIMEOUT - 1));
    assign err_cnt = err_cnt_q;

    // Wait counter restarts on every entry into a request state.
    always_ff @(posedge clk) begin
        if (rst || (state_d != state_q)) begin
            to_cnt_q <= '0;
        end else if (state_q != StIdle) begin
            to_cnt_q <= to_cnt_q + 1'b1;
        end
    end

    // Saturating count of abandoned reads.
    always_ff @(posedge clk) begin
        if (rst) begin
            err_cnt_q <= '0;
        end else if (abandon && (err_cnt_q != 8'hFF)) begin
            err_cnt_q <= err_cnt_q + 1'b1;
        end
    end
`else
    logic unused_timeout;

    assign unused_timeout = ^TIMEOUT;
    assign abandon        = 1'b0;
    assign err_cnt        = '0;
`endif

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; SW[0] only gates the start, never an in-flight pair.
    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle: begin
                if (tick && SW[0]) state_d = StReqX;
            end
            StReqX: begin
                if (rd_ack)       state_d = StReqY;
                else if (abandon) state_d = StIdle;
            end
            StReqY: begin
                if (rd_ack || abandon) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    assign rd_req  = (state_q != StIdle);
    assign rd_axis = (state_q == StReqY);

    // Capture, pending/publish bookkeeping and overwrite counting.
    always_ff @(posedge clk) begin
        if (rst) begin
            vs_prev_q     <= 1'b0;
            shadow_x_q    <= '0;
            pend_x_q      <= '0;
            pend_y_q      <= '0;
            pending_q     <= 1'b0;
            data_x_q      <= '0;
            data_y_q      <= '0;
            data_update_q <= 1'b0;
            ovr_cnt_q     <= '0;
        end else begin
            vs_prev_q     <= v_sync;
            data_update_q <= publish;
            if ((state_q == StReqX) && rd_ack) begin
                shadow_x_q <= rd_data;
            end
            if (publish) begin
                data_x_q <= pend_x_q;
                data_y_q <= pend_y_q;
            end
            if (pair_done) begin
                // Same-cycle publish consumes the old pair, so that is not an overwrite.
                if (pending_q && !publish && (ovr_cnt_q != 8'hFF)) begin
                    ovr_cnt_q <= ovr_cnt_q + 1'b1;
                end
                pending_q <= 1'b1;
                pend_x_q  <= shadow_x_q;
                pend_y_q  <= rd_data;
            end else if (publish) begin
                pending_q <= 1'b0;
            end
        end
    end

    assign data_x      = data_x_q;
    assign data_y      = data_y_q;
    assign data_update = data_update_q;
    assign ovr_cnt     = ovr_cnt_q;

endmodule

// File: tb/tb_sample_sched.sv
// Bench for sample_sched: continuous comparison against a behavioural model, a table of
// read/publish scenarios with hand-derived results, and sequences for timeout, coincident
// completion/edge and reset during a Y read.
`timescale 1ns/1ps
module tb_sample_sched;

    localparam int unsigned DIV = 8;
    localparam int unsigned TO  = 15;
    localparam int unsigned W   = 16;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [9:0]   sw = '0;
    logic         v_sync = 1'b0;
    logic         rd_ack = 1'b0;
    logic [W-1:0] rd_data = '0;
    logic         rd_req, rd_axis, data_update;
    logic [W-1:0] data_x, data_y;
    logic [7:0]   err_cnt, ovr_cnt;

    sample_sched #(.SAMPLE_DIV(DIV), .TIMEOUT(TO), .W(W)) dut (
        .clk(clk), .rst(rst), .SW(sw), .v_sync(v_sync),
        .rd_req(rd_req), .rd_axis(rd_axis), .rd_ack(rd_ack), .rd_data(rd_data),
        .data_x(data_x), .data_y(data_y), .data_update(data_update),
        .err_cnt(err_cnt), .ovr_cnt(ovr_cnt)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Behavioural model: phase 0 = idle, 1 = reading X, 2 = reading Y.
    int           m_cyc, m_phase, m_wait, m_err, m_ovr;
    bit           m_prev_vs, m_pend, m_upd;
    logic [W-1:0] m_sx, m_px, m_py, m_dx, m_dy;

    always @(posedge clk) begin : model
        bit tick, edge_seen, complete, pub;
        if (rst) begin
            m_cyc = 0; m_phase = 0; m_wait = 0; m_err = 0; m_ovr = 0;
            m_prev_vs = 0; m_pend = 0; m_upd = 0;
            m_sx = '0; m_px = '0; m_py = '0; m_dx = '0; m_dy = '0;
        end else begin
            tick      = (m_cyc % DIV) == (DIV - 1);
            m_cyc++;
            edge_seen = v_sync && !m_prev_vs;
            m_prev_vs = v_sync;
            complete  = (m_phase == 2) && rd_ack;
            pub       = edge_seen && m_pend && !sw[1];
            m_upd     = pub;
            if (pub) begin
                m_dx = m_px;
                m_dy = m_py;
            end
            if (complete) begin
                if (m_pend && !pub && m_ovr < 255) m_ovr++;
                m_pend = 1;
                m_px   = m_sx;
                m_py   = rd_data;
            end else if (pub) begin
                m_pend = 0;
            end
            if (m_phase != 0) begin
                if (rd_ack) begin
                    if (m_phase == 1) begin
                        m_sx    = rd_data;
                        m_phase = 2;
                    end else begin
                        m_phase = 0;
                    end
                    m_wait = 0;
                end
`ifdef SAMPLE_SCHED_TIMEOUT_EN
                else begin
                    m_wait++;
                    if (m_wait == TO) begin
                        m_phase = 0;
                        m_wait  = 0;
                        if (m_err < 255) m_err++;
                    end
                end
`endif
            end else if (tick && sw[0]) begin
                m_phase = 1;
                m_wait  = 0;
            end
        end
    end

    bit chk_en = 0;

    always @(negedge clk) begin
        if (chk_en) begin
            chk("model rd_req", rd_req, m_phase != 0);
            chk("model rd_axis", rd_axis, m_phase == 2);
            chk("model data_update", data_update, m_upd);
            chk("model data_x", data_x, m_dx);
            chk("model data_y", data_y, m_dy);
            chk("model err_cnt", err_cnt, m_err);
            chk("model ovr_cnt", ovr_cnt, m_ovr);
        end
    end

    // Auto reader: acks each request after ack_delay idle cycles, data from rd_q.
    bit           rd_auto = 1;
    int           ack_delay = 3;
    int           wcnt = 0;
    logic [W-1:0] rd_q[$];

    always @(negedge clk) begin
        if (rd_auto) begin
            if (rst || m_phase == 0 || rd_ack) begin
                rd_ack = 0;
                wcnt   = 0;
            end else if (wcnt >= ack_delay) begin
                rd_ack = 1;
                if (rd_q.size() != 0) rd_data = rd_q.pop_front();
                else rd_data = W'($urandom);
            end else begin
                wcnt++;
            end
        end
    end

    task automatic wait_req();
        int k = 0;
        while (!rd_req && k < 40) begin
            @(negedge clk);
            k++;
        end
        if (!rd_req) chk("wait rd_req rise", rd_req, 1);
    endtask

    task automatic read_pair();
        int k = 0;
        sw[0] = 1;
        wait_req();
        sw[0] = 0;
        while (rd_req && k < 60) begin
            @(negedge clk);
            k++;
        end
        if (rd_req) chk("wait pair done", rd_req, 0);
    endtask

    task automatic vs_pulse(output int pulses);
        pulses = 0;
        v_sync = 1;
        @(negedge clk);
        if (data_update) pulses++;
        v_sync = 0;
        repeat (3) begin
            @(negedge clk);
            if (data_update) pulses++;
        end
    endtask

    task automatic man_ack(input logic [W-1:0] d);
        rd_data = d;
        rd_ack  = 1;
        @(negedge clk);
        rd_ack  = 0;
    endtask

    typedef struct {
        bit           rd;
        logic [W-1:0] x, y;
        bit           frz;
        int           syncs;
        int           exp_pulses;
        logic [W-1:0] ex, ey;
        int           eovr;
    } row_t;

    row_t tbl[6];

    initial begin
        int           n, p;
        logic [W-1:0] hx, hy;

        tbl[0] = '{1'b1, 16'h1234, 16'hABCD, 1'b0, 1, 1, 16'h1234, 16'hABCD, 0};
        tbl[1] = '{1'b1, 16'h0001, 16'h0002, 1'b0, 0, 0, 16'h1234, 16'hABCD, 0};
        tbl[2] = '{1'b1, 16'h0003, 16'h0004, 1'b0, 1, 1, 16'h0003, 16'h0004, 1};
        tbl[3] = '{1'b1, 16'h5555, 16'h6666, 1'b1, 1, 0, 16'h0003, 16'h0004, 1};
        tbl[4] = '{1'b0, 16'h0000, 16'h0000, 1'b0, 1, 1, 16'h5555, 16'h6666, 1};
        tbl[5] = '{1'b0, 16'h0000, 16'h0000, 1'b0, 1, 0, 16'h5555, 16'h6666, 1};

        rst = 1;
        @(negedge clk);
        chk_en = 1;
        repeat (2) @(negedge clk);
        rst = 0;
        chk("reset rd_req", rd_req, 0);
        chk("reset rd_axis", rd_axis, 0);
        chk("reset data_x", data_x, 0);
        chk("reset data_y", data_y, 0);
        chk("reset data_update", data_update, 0);
        chk("reset err_cnt", err_cnt, 0);
        chk("reset ovr_cnt", ovr_cnt, 0);

        for (int i = 0; i < 6; i++) begin
            p = 0;
            sw[1] = tbl[i].frz;
            if (tbl[i].rd) begin
                rd_q.push_back(tbl[i].x);
                rd_q.push_back(tbl[i].y);
                read_pair();
            end
            for (int s = 0; s < tbl[i].syncs; s++) begin
                vs_pulse(n);
                p += n;
            end
            chk($sformatf("row%0d pulses", i), p, tbl[i].exp_pulses);
            chk($sformatf("row%0d data_x", i), data_x, tbl[i].ex);
            chk($sformatf("row%0d data_y", i), data_y, tbl[i].ey);
            chk($sformatf("row%0d ovr_cnt", i), ovr_cnt, tbl[i].eovr);
        end

        // No ack at all: abandoned after TO cycles, or held indefinitely without the option.
        rd_auto = 0;
        sw[0]   = 1;
        wait_req();
        sw[0]   = 0;
        n = 0;
        for (int k = 0; k < 40; k++) begin
            if (rd_req) n++;
            @(negedge clk);
        end
`ifdef SAMPLE_SCHED_TIMEOUT_EN
        chk("timeout req cycles", n, TO);
        chk("timeout err_cnt", err_cnt, 1);
        chk("timeout data_x", data_x, 16'h5555);
        chk("timeout data_y", data_y, 16'h6666);
        hx = 16'h5555;
        hy = 16'h6666;
`else
        chk("no-timeout req held", n, 40);
        chk("no-timeout err_cnt", err_cnt, 0);
        man_ack(16'h7777);
        man_ack(16'h8888);
        vs_pulse(n);
        chk("late pair pulses", n, 1);
        chk("late pair data_x", data_x, 16'h7777);
        chk("late pair data_y", data_y, 16'h8888);
        hx = 16'h7777;
        hy = 16'h8888;
`endif

        // Pair completion on the same edge as v_sync with nothing pending.
        sw[0] = 1;
        wait_req();
        sw[0] = 0;
        man_ack(16'h0AAA);
        rd_data = 16'h0BBB;
        rd_ack  = 1;
        v_sync  = 1;
        @(negedge clk);
        chk("coincident no pulse", data_update, 0);
        rd_ack = 0;
        v_sync = 0;
        @(negedge clk);
        chk("coincident no late pulse", data_update, 0);
        chk("coincident hold x", data_x, hx);
        chk("coincident hold y", data_y, hy);
        vs_pulse(n);
        chk("coincident next pulses", n, 1);
        chk("coincident next x", data_x, 16'h0AAA);
        chk("coincident next y", data_y, 16'h0BBB);
        chk("coincident ovr_cnt", ovr_cnt, 1);

        // Reset while reading Y: partial pair dropped, outputs cleared.
        sw[0] = 1;
        wait_req();
        sw[0] = 0;
        man_ack(16'h1111);
        chk("in REQ_Y rd_axis", rd_axis, 1);
        rst = 1;
        @(negedge clk);
        rst = 0;
        chk("mid-read reset rd_req", rd_req, 0);
        chk("mid-read reset rd_axis", rd_axis, 0);
        chk("mid-read reset data_x", data_x, 0);
        chk("mid-read reset data_y", data_y, 0);
        chk("mid-read reset data_update", data_update, 0);
        chk("mid-read reset err_cnt", err_cnt, 0);
        chk("mid-read reset ovr_cnt", ovr_cnt, 0);
        p = 0;
        repeat (2) begin
            vs_pulse(n);
            p += n;
        end
        chk("post-reset no pulse", p, 0);
        rd_auto = 1;
        rd_q.push_back(16'h2222);
        rd_q.push_back(16'h3333);
        read_pair();
        vs_pulse(n);
        chk("post-reset pair pulses", n, 1);
        chk("post-reset pair x", data_x, 16'h2222);
        chk("post-reset pair y", data_y, 16'h3333);

        // Randomized traffic, checked against the model every cycle.
        for (int c = 0; c < 3000; c++) begin
            sw[0]  = ($urandom_range(0, 9) != 0);
            sw[1]  = ($urandom_range(0, 7) == 0);
            sw[9:2] = 8'($urandom);
            v_sync = ($urandom_range(0, 3) == 0);
            rst    = ($urandom_range(0, 299) == 0);
            if ($urandom_range(0, 15) == 0) ack_delay = $urandom_range(0, 18);
            @(negedge clk);
        end
        rst = 0;
        sw  = '0;
        repeat (4) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
